// File: rtl/fpdiv_ctrl.sv
// ---------------------------------------------------------------------------
// fpdiv_ctrl
// Control sequencer for the fpdiv Goldschmidt division datapath.
// A divide runs through these steps in order: initial scale (INIT, MDX),
// ITER refinement pairs (COMP, MULT), remainder capture (REM), and a
// one-cycle DONE pulse. Each datapath step lasts MUL_LAT cycles. The selects
// stay stable for the whole step. The step's load enables pulse only in the
// last cycle of the step, so the datapath captures settled multiplier
// results.
//
// Parameters
//   ITER     number of COMP+MULT refinement pairs (0..15)
//   MUL_LAT  cycles per datapath step (1..8)
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      divide request, sampled only while idle
//   sel_muxa   datapath mux A select
//   sel_muxb   datapath mux B select
//   enA/enB    datapath register A/B load enables
//   enC/enR    datapath register C / remainder load enables
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   iter_cnt   completed refinement iterations of the current divide
//
// All outputs are registered. Each output is the decode of the state and
// step counter values that take effect at the same edge, so the outputs are
// a pure function of the registered state.
// ---------------------------------------------------------------------------
module fpdiv_ctrl #(
  parameter int ITER    = 3,
  parameter int MUL_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] sel_muxa,
  output logic [1:0] sel_muxb,
  output logic       enA,
  output logic       enB,
  output logic       enC,
  output logic       enR,
  output logic       busy,
  output logic       done,
  output logic [3:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    MDX  = 3'd2,
    COMP = 3'd3,
    MULT = 3'd4,
    REM  = 3'd5,
    DONE = 3'd6
  } state_t;

  // Index of the last cycle of a step.
  localparam logic [2:0] CYC_LAST = 3'(MUL_LAT - 1);
  // Iteration target, one bit wider than iter_cnt so that iter_cnt+1 cannot wrap.
  localparam logic [4:0] ITER_W   = 5'(ITER);

  state_t     state_r;
  state_t     state_nx_s;
  logic [2:0] cyc_r;
  logic [2:0] cyc_nx_s;
  logic [3:0] iter_nx_s;
  logic       step_end_s;
  logic [7:0] ctl_nx_s;

  // Successor of a datapath step. The caller uses it only at step end.
  function automatic state_t step_next(input state_t st, input logic [3:0] iter_done);
    state_t nx;
    case (st)
      INIT:    nx = MDX;
      MDX:     nx = (ITER_W != 5'd0) ? COMP : REM;
      COMP:    nx = MULT;
      // iter_done does not yet count the MULT step that is finishing now.
      MULT:    nx = (({1'b0, iter_done} + 5'd1) < ITER_W) ? COMP : REM;
      REM:     nx = DONE;
      default: nx = IDLE;
    endcase
    return nx;
  endfunction

  // Control word for a state: {muxa[1:0], muxb[1:0], enA, enB, enC, enR}.
  // 'last' is high in the final cycle of the step and gates every enable.
  function automatic logic [7:0] decode_ctl(input state_t st, input logic last);
    logic [7:0] c;
    case (st)
      IDLE:    c = {2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
      INIT:    c = {2'b10, 2'b01, 1'b0, last, 1'b0, 1'b0};
      MDX:     c = {2'b10, 2'b00, last, 1'b0, last, 1'b0};
      COMP:    c = {2'b00, 2'b10, 1'b0, last, 1'b0, 1'b0};
      MULT:    c = {2'b00, 2'b11, last, 1'b0, last, 1'b0};
      REM:     c = {2'b01, 2'b10, 1'b0, 1'b0, 1'b0, last};
      DONE:    c = {2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
      default: c = {2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    endcase
    return c;
  endfunction

  // Next-state, step-counter and iteration-counter logic.
  always_comb begin
    state_nx_s = state_r;
    cyc_nx_s   = cyc_r;
    iter_nx_s  = iter_cnt;
    step_end_s = (cyc_r == CYC_LAST);
    case (state_r)
      IDLE: begin
        cyc_nx_s = 3'd0;
        if (start) begin
          state_nx_s = INIT;
          iter_nx_s  = 4'd0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      INIT, MDX, COMP, MULT, REM: begin
        if (step_end_s) begin
          cyc_nx_s   = 3'd0;
          state_nx_s = step_next(state_r, iter_cnt);
          if (state_r == MULT) begin
            iter_nx_s = iter_cnt + 4'd1;
          end else begin
            iter_nx_s = iter_cnt;
          end
        end else begin
          cyc_nx_s = cyc_r + 3'd1;
        end
      end
      // DONE lasts a single cycle and ignores the step counter.
      DONE: begin
        state_nx_s = IDLE;
        cyc_nx_s   = 3'd0;
      end
      default: begin
        state_nx_s = IDLE;
        cyc_nx_s   = 3'd0;
      end
    endcase
    // Enables fire when the next cycle is the last cycle of its step.
    ctl_nx_s = decode_ctl(state_nx_s, (cyc_nx_s == CYC_LAST));
  end

  // State registers and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cyc_r    <= 3'd0;
      iter_cnt <= 4'd0;
      sel_muxa <= 2'b10;
      sel_muxb <= 2'b01;
      enA      <= 1'b0;
      enB      <= 1'b0;
      enC      <= 1'b0;
      enR      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      cyc_r    <= cyc_nx_s;
      iter_cnt <= iter_nx_s;
      {sel_muxa, sel_muxb, enA, enB, enC, enR} <= ctl_nx_s;
      busy     <= (state_nx_s != IDLE);
      done     <= (state_nx_s == DONE);
    end
  end

endmodule
